// File: rtl/regop_pkg.sv
// Shared types and default widths for the register-operation sequencer slice.
// Opcode and FSM state encodings are used by the sequencer and its ALU.
package regop_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int RADDR_W_DEF = 2;

    typedef enum logic [1:0] {
        OP_LDI = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_MOV = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/regop_alu.sv
// Combinational ALU for the sequencer: produces a result one bit wider than the data.
// The top bit is the ADD carry / SUB borrow and is zero for LDI and MOV.
module regop_alu
    import regop_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  opcode_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W:0]   res
);

    // Result select; the extra top bit captures carry or borrow.
    always_comb begin
        res = '0;
        case (op)
            OP_LDI:  res = {1'b0, imm};
            OP_ADD:  res = {1'b0, a} + {1'b0, b};
            OP_SUB:  res = {1'b0, a} - {1'b0, b};
            OP_MOV:  res = {1'b0, a};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/regop_sequencer.sv
// Multi-cycle read / execute / write-back controller for an external 4x8 register file.
// One operation at a time; requests arriving while busy are dropped.
module regop_sequencer
    import regop_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         opcode,
    input  logic [RADDR_W-1:0] rd,
    input  logic [RADDR_W-1:0] rs1,
    input  logic [RADDR_W-1:0] rs2,
    input  logic [DATA_W-1:0]  imm,
    output logic [RADDR_W-1:0] rf_sel_a,
    output logic [RADDR_W-1:0] rf_sel_b,
    input  logic [DATA_W-1:0]  rf_data_a,
    input  logic [DATA_W-1:0]  rf_data_b,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_sel_w,
    output logic [DATA_W-1:0]  rf_data_w,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result,
    output logic               flag_z,
    output logic               flag_c
);

    state_t             state_r;
    opcode_t            opcode_r;
    logic [RADDR_W-1:0] rd_r;
    logic [DATA_W-1:0]  imm_r;
    logic [DATA_W-1:0]  op_a_r;
    logic [DATA_W-1:0]  op_b_r;
    logic [DATA_W:0]    res_r;
    logic [DATA_W:0]    alu_res_s;

    regop_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op  (opcode_r),
        .a   (op_a_r),
        .b   (op_b_r),
        .imm (imm_r),
        .res (alu_res_s)
    );

    // Sequencer FSM with all outputs registered; rs1/rs2 are latched straight into the read selects.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            opcode_r  <= OP_LDI;
            rd_r      <= '0;
            imm_r     <= '0;
            op_a_r    <= '0;
            op_b_r    <= '0;
            res_r     <= '0;
            rf_sel_a  <= '0;
            rf_sel_b  <= '0;
            rf_we     <= 1'b0;
            rf_sel_w  <= '0;
            rf_data_w <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            done  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        opcode_r <= opcode_t'(opcode);
                        rd_r     <= rd;
                        imm_r    <= imm;
                        rf_sel_a <= rs1;
                        rf_sel_b <= rs2;
                        busy     <= 1'b1;
                        state_r  <= S_READ;
                    end else begin
                        state_r  <= S_IDLE;
                    end
                end
                S_READ: begin
                    op_a_r  <= rf_data_a;
                    op_b_r  <= rf_data_b;
                    state_r <= S_EXEC;
                end
                S_EXEC: begin
                    // Write port is loaded here so rf_we is high exactly during WRITE.
                    res_r     <= alu_res_s;
                    rf_we     <= 1'b1;
                    rf_sel_w  <= rd_r;
                    rf_data_w <= alu_res_s[DATA_W-1:0];
                    state_r   <= S_WRITE;
                end
                S_WRITE: begin
                    result  <= res_r[DATA_W-1:0];
                    flag_z  <= (res_r[DATA_W-1:0] == '0);
                    flag_c  <= res_r[DATA_W];
                    done    <= 1'b1;
                    state_r <= S_DONE;
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regop_sequencer.sv
// Scoreboard bench for regop_sequencer: a reference model pushes expected write-backs at accept
// time, and a negedge monitor checks them when rf_we / done appear.
module tb_regop_sequencer;
    import regop_pkg::*;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [1:0]    opcode;
    logic [AW-1:0] rd, rs1, rs2;
    logic [DW-1:0] imm;
    logic [AW-1:0] rf_sel_a, rf_sel_b, rf_sel_w;
    logic [DW-1:0] rf_data_a, rf_data_b, rf_data_w;
    logic          rf_we, busy, done, flag_z, flag_c;
    logic [DW-1:0] result;

    logic [DW-1:0] rf_mem [4] = '{default: 8'h00};
    logic [DW-1:0] ref_rf [4] = '{default: 8'h00};

    typedef struct {
        int            acc;
        logic [AW-1:0] rd;
        logic [DW-1:0] val;
        logic          z;
        logic          c;
        logic [DW-1:0] old;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   free_at = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_we = 0;
    int   n_done = 0;

    regop_sequencer #(.DATA_W(DW), .RADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .rf_sel_a  (rf_sel_a),
        .rf_sel_b  (rf_sel_b),
        .rf_data_a (rf_data_a),
        .rf_data_b (rf_data_b),
        .rf_we     (rf_we),
        .rf_sel_w  (rf_sel_w),
        .rf_data_w (rf_data_w),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .flag_z    (flag_z),
        .flag_c    (flag_c)
    );

    always #10 clk = ~clk;

    // Behavioural register file: combinational reads, write on the clock edge.
    assign rf_data_a = rf_mem[rf_sel_a];
    assign rf_data_b = rf_mem[rf_sel_b];
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_sel_w] <= rf_data_w;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: an op is accepted when start is seen and the previous op has had its 5 cycles.
    initial begin
        exp_t e;
        int a, b, s, v, c;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                while (q.size() > 0) begin
                    e = q.pop_back();
                    if (cyc <= e.acc + 2) ref_rf[e.rd] = e.old;
                end
                free_at = cyc + 1;
            end else if (start && cyc >= free_at) begin
                a = int'(ref_rf[rs1]);
                b = int'(ref_rf[rs2]);
                c = 0;
                case (opcode)
                    2'd0: v = int'(imm);
                    2'd1: begin s = a + b; v = s % 256; c = (s > 255) ? 1 : 0; end
                    2'd2: begin v = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
                    default: v = a;
                endcase
                e.acc = cyc;
                e.rd  = rd;
                e.val = 8'(v);
                e.z   = (v == 0);
                e.c   = (c != 0);
                e.old = ref_rf[rd];
                ref_rf[rd] = 8'(v);
                q.push_back(e);
                free_at = cyc + 5;
            end
        end
    end

    // Monitor: compares busy every cycle and pops the scoreboard on write-back and done.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                chk("busy", 32'(busy), 32'(q.size() > 0));
                if (rf_we) begin
                    n_we++;
                    if (q.size() == 0) begin
                        chk("rf_we_unexpected", 32'(rf_we), 32'd0);
                    end else begin
                        chk("we_cycle", 32'(cyc), 32'(q[0].acc + 2));
                        chk("sel_w", 32'(rf_sel_w), 32'(q[0].rd));
                        chk("data_w", 32'(rf_data_w), 32'(q[0].val));
                    end
                end
                if (done) begin
                    n_done++;
                    if (q.size() == 0) begin
                        chk("done_unexpected", 32'(done), 32'd0);
                    end else begin
                        chk("done_cycle", 32'(cyc), 32'(q[0].acc + 3));
                        chk("result", 32'(result), 32'(q[0].val));
                        chk("flag_z", 32'(flag_z), 32'(q[0].z));
                        chk("flag_c", 32'(flag_c), 32'(q[0].c));
                        void'(q.pop_front());
                    end
                end else if (q.size() > 0 && cyc > q[0].acc + 3) begin
                    chk("done_timeout", 32'(done), 32'd1);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic set_in(input int op, input int d, input int s1, input int s2, input int im);
        opcode = 2'(op);
        rd     = 2'(d);
        rs1    = 2'(s1);
        rs2    = 2'(s2);
        imm    = 8'(im);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        if (k == 20) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input int op, input int d, input int s1, input int s2, input int im);
        wait_idle();
        set_in(op, d, s1, s2, im);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_idle();
    endtask

    task automatic set_random();
        set_in(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
    endtask

    initial begin
        int nw, nd;
        reset = 1'b1;
        start = 1'b0;
        set_in(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({flag_z, flag_c}), 32'd0);
        chk("rst_sels", 32'({rf_sel_a, rf_sel_b, rf_sel_w}), 32'd0);
        chk("rst_data_w", 32'(rf_data_w), 32'd0);
        reset = 1'b0;

        // Directed arithmetic cases.
        run_op(0, 1, 0, 0, 8'h3C);
        chk("ldi_r1", 32'(rf_mem[1]), 32'h3C);
        run_op(0, 2, 0, 0, 8'h05);
        run_op(1, 3, 1, 2, 0);
        chk("add_r3", 32'(rf_mem[3]), 32'h41);
        run_op(2, 0, 2, 1, 0);
        chk("sub_r0", 32'(rf_mem[0]), 32'hC9);
        chk("sub_borrow", 32'(flag_c), 32'd1);
        run_op(3, 2, 2, 0, 0);
        chk("mov_r2", 32'(rf_mem[2]), 32'h05);
        chk("mov_c", 32'(flag_c), 32'd0);
        run_op(0, 1, 0, 0, 8'hFF);
        run_op(0, 2, 0, 0, 8'h01);
        run_op(1, 3, 1, 2, 0);
        chk("wrap_r3", 32'(rf_mem[3]), 32'h00);
        chk("wrap_zc", 32'({flag_z, flag_c}), 32'h3);

        // Start re-pulsed and inputs scrambled while busy: only the latched op executes.
        nw = n_we; nd = n_done;
        set_in(1, 0, 1, 2, 0);
        start = 1'b1;
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            set_random();
            start = 1'b1;
            @(negedge clk); #1;
        end
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        #1;
        chk("busy_one_we", 32'(n_we - nw), 32'd1);
        chk("busy_one_done", 32'(n_done - nd), 32'd1);
        chk("latched_r0", 32'(rf_mem[0]), 32'h00);

        // Reset asserted during EXEC aborts the write.
        nw = n_we;
        set_in(0, 0, 0, 0, 8'h77);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("abort_no_we", 32'(n_we - nw), 32'd0);
        chk("abort_r0", 32'(rf_mem[0]), 32'(ref_rf[0]));
        run_op(0, 0, 0, 0, 8'hA5);
        chk("post_abort_r0", 32'(rf_mem[0]), 32'hA5);

        // Start held for 20 cycles: back-to-back ops every 5 cycles.
        nd = n_done;
        for (int i = 0; i < 20; i++) begin
            set_random();
            start = 1'b1;
            @(negedge clk); #1;
        end
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        #1;
        chk("held_done_count", 32'(n_done - nd), 32'd4);

        // Random traffic with random gaps and stray start pulses.
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #1;
            set_random();
            start = 1'b1;
            @(negedge clk); #1;
            start = 1'b0;
        end
        wait_idle();
        repeat (3) @(negedge clk);
        #1;
        for (int r = 0; r < 4; r++) chk("final_rf", 32'(rf_mem[r]), 32'(ref_rf[r]));
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
